// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the MIPS pipeline. It holds the program counter and reads a
// word-addressed instruction memory combinationally at the current PC. The
// fetched word and PC+4 are registered into the IF/ID pipeline register. Fetch
// is redirected by jumps and taken branches that were resolved in decode, and
// hazard logic can stall or flush the stage.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   stall          hold the PC and the IF/ID register
//   flush          load a bubble into IF/ID; the PC still advances
//   branch_taken   redirect to the branch target (already qualified)
//   branch_offset  raw 16-bit immediate of the branch held in IF/ID
//   jump           redirect to the jump target
//   jump_index     raw 26-bit index of the jump held in IF/ID
//   imem_we        instruction memory write enable (loader)
//   imem_waddr     word address for the write
//   imem_wdata     write data
//   pc             current fetch PC
//   instruction    IF/ID instruction, drives decode
//   pc_plus4       IF/ID PC+4 of that instruction
//   id_valid       IF/ID holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          branch_taken,
    input  logic [15:0]                   branch_offset,
    input  logic                          jump,
    input  logic [25:0]                   jump_index,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   instruction,
    output logic [31:0]                   pc_plus4,
    output logic                          id_valid
);

    localparam int ADDR_W = $clog2(IMEM_DEPTH);

    // A bubble decodes as sll $0,$0,0, which is a NOP.
    localparam logic [31:0] BUBBLE = 32'h0000_0000;

    logic [31:0]       imem [IMEM_DEPTH];
    logic [ADDR_W-1:0] fetchIndex;
    logic [31:0]       fetchWord;
    logic [31:0]       seqPc;
    logic [31:0]       branchTarget;
    logic [31:0]       jumpTarget;
    logic [31:0]       offsetBytes;

    // Memory is word addressed; upper PC bits are dropped so fetches wrap
    // modulo the memory depth.
    assign fetchIndex = pc[ADDR_W+1:2];
    assign fetchWord  = imem[fetchIndex];

    // Redirect targets are relative to the instruction currently in IF/ID,
    // which is the branch or jump being resolved in decode.
    assign seqPc        = pc + 32'd4;
    assign offsetBytes  = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign branchTarget = pc_plus4 + offsetBytes;
    assign jumpTarget   = {pc_plus4[31:28], jump_index, 2'b00};

    // Loader write port. The fetch read above sees the pre-edge contents, so
    // a same-cycle write to the fetched address returns the old word.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // PC and IF/ID register. Stall freezes everything and masks redirects;
    // jump beats branch, and any redirect or flush squashes the single
    // wrong-path instruction by loading a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            instruction <= BUBBLE;
            pc_plus4    <= 32'd0;
            id_valid    <= 1'b0;
        end else if (!stall) begin
            if (jump) begin
                pc          <= jumpTarget;
                instruction <= BUBBLE;
                pc_plus4    <= 32'd0;
                id_valid    <= 1'b0;
            end else if (branch_taken) begin
                pc          <= branchTarget;
                instruction <= BUBBLE;
                pc_plus4    <= 32'd0;
                id_valid    <= 1'b0;
            end else if (flush) begin
                pc          <= seqPc;
                instruction <= BUBBLE;
                pc_plus4    <= 32'd0;
                id_valid    <= 1'b0;
            end else begin
                pc          <= seqPc;
                instruction <= fetchWord;
                pc_plus4    <= seqPc;
                id_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Drives three instances of instruction_fetch with a shared stimulus stream:
// the default reset PC, a reset PC at the top of the address space (to show
// PC wrap) and one in the 0x8000_0000 region (so a jump keeps a non-zero
// upper nibble). A behavioural model of each instance is compared against the
// outputs every cycle, and directed literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int DEPTH = 256;
    localparam int NDUT  = 3;

    localparam logic [31:0] RESET_PCS [NDUT] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h8000_000C};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = 8'h0;
    logic [31:0] imem_wdata = 32'h0;

    logic [31:0] pcOut [NDUT];
    logic [31:0] instrOut [NDUT];
    logic [31:0] pp4Out [NDUT];
    logic        validOut [NDUT];

    int checkCount = 0;
    int errorCount = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dutMain (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pcOut[0]), .instruction(instrOut[0]), .pc_plus4(pp4Out[0]), .id_valid(validOut[0])
    );

    instruction_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pcOut[1]), .instruction(instrOut[1]), .pc_plus4(pp4Out[1]), .id_valid(validOut[1])
    );

    instruction_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h8000_000C)) dutHigh (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pcOut[2]), .instruction(instrOut[2]), .pc_plus4(pp4Out[2]), .id_valid(validOut[2])
    );

    // Behavioural model: memory contents plus per-instance PC and IF/ID.
    logic [31:0] modelMem [DEPTH];
    logic [31:0] mPc [NDUT];
    logic [31:0] mInstr [NDUT];
    logic [31:0] mPp4 [NDUT];
    logic        mValid [NDUT];

    task automatic modelReset();
        for (int k = 0; k < NDUT; k++) begin
            mPc[k]    = RESET_PCS[k];
            mInstr[k] = 32'h0;
            mPp4[k]   = 32'h0;
            mValid[k] = 1'b0;
        end
    endtask

    task automatic modelBubble(input int k);
        mInstr[k] = 32'h0;
        mPp4[k]   = 32'h0;
        mValid[k] = 1'b0;
    endtask

    initial modelReset();

    always @(negedge reset_n) modelReset();

    // One clock edge of the model: priority stall > jump > branch > flush.
    always @(posedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < NDUT; k++) begin
                if (!stall) begin
                    if (jump) begin
                        mPc[k] = (mPp4[k] & 32'hF000_0000) | (32'(jump_index) * 4);
                        modelBubble(k);
                    end else if (branch_taken) begin
                        mPc[k] = mPp4[k] + 32'(int'($signed(branch_offset)) * 4);
                        modelBubble(k);
                    end else if (flush) begin
                        mPc[k] = mPc[k] + 32'd4;
                        modelBubble(k);
                    end else begin
                        mInstr[k] = modelMem[int'((mPc[k] / 4) % DEPTH)];
                        mPp4[k]   = mPc[k] + 32'd4;
                        mValid[k] = 1'b1;
                        mPc[k]    = mPc[k] + 32'd4;
                    end
                end
            end
        end
        if (imem_we) modelMem[imem_waddr] = imem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Model comparison on every cycle, away from the rising edge.
    always @(negedge clk) begin
        #1;
        if (checkEn) begin
            for (int k = 0; k < NDUT; k++) begin
                checkOutput($sformatf("model%0d.pc", k), pcOut[k], mPc[k]);
                checkOutput($sformatf("model%0d.instruction", k), instrOut[k], mInstr[k]);
                checkOutput($sformatf("model%0d.pc_plus4", k), pp4Out[k], mPp4[k]);
                checkOutput($sformatf("model%0d.id_valid", k), 32'(validOut[k]), 32'(mValid[k]));
            end
        end
    end

    // Drive one edge worth of inputs, then return shortly after the edge.
    task automatic applyStimulus(input logic s, input logic f, input logic b, input logic [15:0] off,
                                 input logic j, input logic [25:0] idx,
                                 input logic we, input logic [7:0] wa, input logic [31:0] wd);
        stall = s; flush = f; branch_taken = b; branch_offset = off;
        jump = j; jump_index = idx; imem_we = we; imem_waddr = wa; imem_wdata = wd;
        @(posedge clk);
        #2;
    endtask

    task automatic idleEdge();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic checkIfId(input string tag, input int k, input logic [31:0] pcExp,
                             input logic [31:0] instrExp, input logic [31:0] pp4Exp, input logic validExp);
        checkOutput({tag, ".pc"}, pcOut[k], pcExp);
        checkOutput({tag, ".instruction"}, instrOut[k], instrExp);
        checkOutput({tag, ".pc_plus4"}, pp4Out[k], pp4Exp);
        checkOutput({tag, ".id_valid"}, 32'(validOut[k]), 32'(validExp));
    endtask

    initial begin
        logic [31:0] seqWords [4];
        seqWords = '{32'h11, 32'h22, 32'h33, 32'h44};

        // Load memory while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] word;
            if (i < 4)           word = seqWords[i];
            else if (i == 255)   word = 32'hAB;
            else                 word = {16'hC0DE, 16'(i)};
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 8'(i), word);
        end
        idleEdge();
        checkEn = 1'b1;

        checkIfId("reset.main", 0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("reset.wrap.pc", pcOut[1], 32'hFFFF_FFFC);

        // Sequential fetch.
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idleEdge();
            checkIfId($sformatf("seq%0d", i), 0, 32'(4 * (i + 1)), seqWords[i], 32'(4 * (i + 1)), 1'b1);
        end

        // Backward branch from pc_plus4 = 0x10 to 0.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 8'h0, 32'h0);
        checkIfId("branchBack", 0, 32'h0, 32'h0, 32'h0, 1'b0);
        idleEdge();
        checkIfId("branchTarget", 0, 32'h4, 32'h11, 32'h4, 1'b1);

        // Stall masks a held branch and flush.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 8'h0, 32'h0);
            checkIfId($sformatf("stall%0d", i), 0, 32'h4, 32'h11, 32'h4, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 8'h0, 32'h0);
        checkIfId("stallRelease", 0, 32'h14, 32'h0, 32'h0, 1'b0);
        idleEdge();
        checkIfId("afterStall0", 0, 32'h18, 32'hC0DE_0005, 32'h18, 1'b1);
        idleEdge();
        checkIfId("afterStall1", 0, 32'h1C, 32'hC0DE_0006, 32'h1C, 1'b1);

        // Write to the word being fetched: old word now, new word on refetch.
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 8'd7, 32'hDEAD_BEEF);
        checkIfId("writeCollide", 0, 32'h20, 32'hC0DE_0007, 32'h20, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 26'h0, 1'b0, 8'h0, 32'h0);
        checkIfId("refetchBranch", 0, 32'h1C, 32'h0, 32'h0, 1'b0);
        idleEdge();
        checkIfId("refetch", 0, 32'h20, 32'hDEAD_BEEF, 32'h20, 1'b1);

        // Asynchronous reset dropped between edges during a branch.
        branch_taken = 1'b1;
        branch_offset = 16'hFFFC;
        #2;
        reset_n = 1'b0;
        #1;
        checkIfId("asyncReset", 0, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 8'h0, 32'h0);
        checkIfId("resetHeld", 0, 32'h0, 32'h0, 32'h0, 1'b0);
        reset_n = 1'b1;

        // Restart after reset, wrap instance, then flush.
        idleEdge();
        checkIfId("restart", 0, 32'h4, 32'h11, 32'h4, 1'b1);
        checkIfId("wrapFirst", 1, 32'h0, 32'hAB, 32'h0, 1'b1);
        checkIfId("highFirst", 2, 32'h8000_0010, 32'h44, 32'h8000_0010, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 8'h0, 32'h0);
        checkIfId("wrapFlush", 1, 32'h4, 32'h0, 32'h0, 1'b0);
        checkIfId("mainFlush", 0, 32'h8, 32'h0, 32'h0, 1'b0);

        // Jump together with a taken branch: jump wins.
        reset_n = 1'b0;
        idleEdge();
        reset_n = 1'b1;
        idleEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFC, 1'b1, 26'h10, 1'b0, 8'h0, 32'h0);
        checkIfId("highJump", 2, 32'h8000_0040, 32'h0, 32'h0, 1'b0);
        checkIfId("mainJump", 0, 32'h40, 32'h0, 32'h0, 1'b0);
        idleEdge();
        checkIfId("highJumpTarget", 2, 32'h8000_0044, 32'hC0DE_0010, 32'h8000_0044, 1'b1);

        idleEdge();
        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
